ebus_diag_rd: RTL and testbench
===============================

// Module: ebus_diag_rd
// PURPOSE
//  EBUS diagnostic-read initiator: the requesting end of the DIAG read-function
//  path that the EBOX data path answers (DIAG function 12x, register
//  select = DIAG[4:6]). Accepts one function code from the front-end side,
//  drives it onto EBUS with a strobe and waits for a responder to drive data.
//  It captures the 36-bit word and returns it, or flags a timeout.
// PARAMETERS
//  SETUP_CYC   2   cycles function code is driven before strobe asserts (>=1)
//  SAMPLE_DLY  1   extra consecutive ebus_driving cycles required before capture
//  TIMEOUT     63  max STROBE cycles without capture before abort (>=SAMPLE_DLY+1)
// PORTS
//  clk           in   1   EBOX clock; all state on posedge
//  rst_n         in   1   asynchronous, active-low reset
//  req_valid     in   1   request present
//  req_ready     out  1   block idle, request accepted when valid&ready
//  req_func      in   7   DIAG function code (e.g. 7'o120..7'o127)
//  rsp_valid     out  1   response held until rsp_ready
//  rsp_ready     in   1   consumer takes response
//  rsp_data      out  36  captured EBUS word [0:35]; 0 on timeout
//  rsp_timeout   out  1   response is a timeout (qualified by rsp_valid)
//  ebus_diag     out  7   function code onto EBUS DIAG lines
//  ebus_strobe   out  1   diagnostic strobe
//  ebus_data     in   36  EBUS data lines
//  ebus_driving  in   1   OR of all responders' EBUSdriver.driving
// BEHAVIOUR
//  Reset: state IDLE; req_ready=1; rsp_valid=0; rsp_data=0; rsp_timeout=0;
//   ebus_diag=0; ebus_strobe=0; all counters 0. Reset mid-op aborts immediately,
//   with no response produced.
//  FSM IDLE->SETUP->STROBE->HOLD->IDLE.
//  IDLE: req_ready=1. req_valid at an edge latches req_func and enters SETUP.
//  SETUP: ebus_diag=latched code, strobe=0, lasts exactly SETUP_CYC cycles.
//  STROBE: ebus_diag held, strobe=1. The settle counter counts consecutive
//   cycles with ebus_driving=1 and clears on any cycle with ebus_driving=0
//   (a glitching responder restarts the settle count). On the edge where
//   driving=1 and settle==SAMPLE_DLY, latch ebus_data into rsp_data with
//   rsp_timeout=0 and enter HOLD. The timeout counter increments every STROBE
//   cycle. If it reaches TIMEOUT-1 on a cycle with no capture, that edge sets
//   rsp_data=0, rsp_timeout=1 and enters HOLD. If capture and timeout coincide,
//   capture wins.
//  HOLD: ebus_diag=0, strobe=0, rsp_valid=1; rsp_data and rsp_timeout stable.
//   An edge with rsp_ready=1 enters IDLE and clears rsp_valid. rsp_ready in
//   other states is ignored.
//  Latency (defaults, driving=1 from first STROBE cycle): accept edge T,
//   SETUP T+1..T+2, STROBE T+3..T+4, rsp_valid=1 from T+5.
//  No request queueing: req_ready=0 outside IDLE; a new request can be accepted
//   no earlier than the cycle after rsp handshake. ebus_data is sampled only at
//   the capture edge.
//  Counters saturate and never wrap. Counter width is $clog2(TIMEOUT+1).
// CONFIGURATION
//  EBUS_DIAG_PARITY_EN defined: adds ebus_par (in, 1) and rsp_par_err (out, 1).
//   rsp_par_err = ~^{ebus_data,ebus_par} (odd parity), latched at capture.
//   rsp_par_err is forced 0 on timeout and is 0 at reset.
//  Undefined: these ports and their logic are absent; there is no parity check.
// TESTING
//  1 req_func=7'o120, responder drives 36'o123456_701234 from first strobe
//    cycle -> rsp_valid at T+5, rsp_data=36'o123456701234, rsp_timeout=0.
//  2 No responder (driving=0) -> strobe high 63 cycles, then rsp_valid,
//    rsp_timeout=1, rsp_data=0; ebus_strobe=0 in HOLD.
//  3 driving pattern 1,0,1,1 in STROBE -> capture on the 4th STROBE cycle edge,
//    with data from that cycle.
//  4 rsp_ready held 0 for 10 cycles -> rsp_valid/rsp_data stable, req_ready=0
//    and a second req_valid is ignored; after rsp_ready=1, one response only.
//  5 rst_n low during STROBE -> outputs immediately at reset values; after
//    release, a fresh request completes normally.
//  6 (EBUS_DIAG_PARITY_EN) data 36'o0 with ebus_par=0 -> rsp_par_err=1;
//    with ebus_par=1 -> rsp_par_err=0.

Source files
------------

// File: rtl/ebus_diag_rd.sv
// EBUS diagnostic-read initiator: drives a DIAG function code and strobe, waits
// for a settled responder, then returns the captured 36-bit word or a timeout.
// Optional odd-parity check on the captured word: define EBUS_DIAG_PARITY_EN.
module ebus_diag_rd #(
  parameter int SETUP_CYC  = 2,
  parameter int SAMPLE_DLY = 1,
  parameter int TIMEOUT    = 63
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [6:0]  req_func,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [35:0] rsp_data,
  output logic        rsp_timeout,
  output logic [6:0]  ebus_diag,
  output logic        ebus_strobe,
  input  logic [35:0] ebus_data,
  input  logic        ebus_driving
`ifdef EBUS_DIAG_PARITY_EN
  ,
  input  logic        ebus_par,
  output logic        rsp_par_err
`endif
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    STROBE,
    HOLD
  } state_t;

  state_t        state;
  logic [CW-1:0] setup_cnt;
  logic [CW-1:0] settle_cnt;
  logic [CW-1:0] tmo_cnt;
  logic          capture;
  logic          tmo_hit;

  // The responder has held the bus for SAMPLE_DLY cycles before this one.
  assign capture = ebus_driving && (settle_cnt == CW'(SAMPLE_DLY));
  assign tmo_hit = (tmo_cnt == CW'(TIMEOUT - 1));

  // NOTE: state and registered outputs use non-blocking assignments only, so
  // every branch below reads the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      req_ready   <= 1'b1;
      rsp_valid   <= 1'b0;
      rsp_data    <= '0;
      rsp_timeout <= 1'b0;
      ebus_diag   <= '0;
      ebus_strobe <= 1'b0;
      setup_cnt   <= '0;
      settle_cnt  <= '0;
      tmo_cnt     <= '0;
`ifdef EBUS_DIAG_PARITY_EN
      rsp_par_err <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            ebus_diag <= req_func;
            req_ready <= 1'b0;
            setup_cnt <= '0;
            state     <= SETUP;
          end
        end

        SETUP: begin
          if (setup_cnt == CW'(SETUP_CYC - 1)) begin
            ebus_strobe <= 1'b1;
            setup_cnt   <= '0;
            settle_cnt  <= '0;
            tmo_cnt     <= '0;
            state       <= STROBE;
          end else if (setup_cnt != '1) begin
            setup_cnt <= setup_cnt + CW'(1);
          end
        end

        STROBE: begin
          // Capture is tested first so it wins on the final timeout cycle.
          if (capture || tmo_hit) begin
            rsp_data    <= capture ? ebus_data : '0;
            rsp_timeout <= !capture;
`ifdef EBUS_DIAG_PARITY_EN
            rsp_par_err <= capture ? ~^{ebus_data, ebus_par} : 1'b0;
`endif
            rsp_valid   <= 1'b1;
            ebus_strobe <= 1'b0;
            ebus_diag   <= '0;
            settle_cnt  <= '0;
            tmo_cnt     <= '0;
            state       <= HOLD;
          end else begin
            if (tmo_cnt != '1) begin
              tmo_cnt <= tmo_cnt + CW'(1);
            end
            if (!ebus_driving) begin
              settle_cnt <= '0;
            end else if (settle_cnt != '1) begin
              settle_cnt <= settle_cnt + CW'(1);
            end
          end
        end

        HOLD: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            state     <= IDLE;
          end
        end

        default: begin
          state       <= IDLE;
          req_ready   <= 1'b1;
          rsp_valid   <= 1'b0;
          ebus_strobe <= 1'b0;
          ebus_diag   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ebus_diag_rd.sv
// Scoreboard bench for ebus_diag_rd: randomized responder patterns checked
// against a cycle-list model of the capture/timeout rules.
module tb_ebus_diag_rd;

  localparam int SETUP_CYC  = 2;
  localparam int SAMPLE_DLY = 1;
  localparam int TIMEOUT    = 63;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [6:0]  req_func = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [35:0] rsp_data;
  logic        rsp_timeout;
  logic [6:0]  ebus_diag;
  logic        ebus_strobe;
  logic [35:0] ebus_data = '0;
  logic        ebus_driving = 1'b0;
`ifdef EBUS_DIAG_PARITY_EN
  logic        ebus_par = 1'b0;
  logic        rsp_par_err;
`endif

  ebus_diag_rd #(
    .SETUP_CYC (SETUP_CYC),
    .SAMPLE_DLY(SAMPLE_DLY),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_func    (req_func),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_data    (rsp_data),
    .rsp_timeout (rsp_timeout),
    .ebus_diag   (ebus_diag),
    .ebus_strobe (ebus_strobe),
    .ebus_data   (ebus_data),
    .ebus_driving(ebus_driving)
`ifdef EBUS_DIAG_PARITY_EN
    ,
    .ebus_par    (ebus_par),
    .rsp_par_err (rsp_par_err)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [6:0]  func;
    logic [35:0] data;
    logic        tmo;
    logic        par_err;
    int          nstrobe;
    int          lat;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  // Responder script, indexed by STROBE cycle number.
  logic        drv [TIMEOUT];
  logic [35:0] dat [TIMEOUT];
  logic        par [TIMEOUT];

  int ready_delay = 1;
  bit ready_noise = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [35:0] rand36();
    return {4'($urandom), 32'($urandom)};
  endfunction

  // Reference: walk the scripted bus cycles and find the first cycle that
  // completes a run of SAMPLE_DLY+1 consecutive driving cycles.
  function automatic exp_t model(input logic [6:0] func);
    exp_t e;
    int   run = 0;
    int   k = -1;
    e.func    = func;
    e.data    = '0;
    e.tmo     = 1'b1;
    e.par_err = 1'b0;
    e.nstrobe = TIMEOUT;
    for (int i = 0; i < TIMEOUT; i++) begin
      run = drv[i] ? run + 1 : 0;
      if (run == SAMPLE_DLY + 1) begin
        k = i;
        break;
      end
    end
    if (k >= 0) begin
      e.data    = dat[k];
      e.tmo     = 1'b0;
      e.par_err = ((($countones(dat[k]) + (par[k] ? 1 : 0)) % 2) == 0);
      e.nstrobe = k + 1;
    end
    e.lat = SETUP_CYC + e.nstrobe;
    return e;
  endfunction

  // kind: 0 always driving, 1 never, 2 glitchy 50%, 3 glitchy 85%, 4 late start
  task automatic fill(input int kind);
    int start = $urandom_range(0, 70);
    for (int i = 0; i < TIMEOUT; i++) begin
      dat[i] = rand36();
      par[i] = 1'($urandom);
      case (kind)
        0:       drv[i] = 1'b1;
        1:       drv[i] = 1'b0;
        2:       drv[i] = ($urandom_range(0, 99) < 50);
        3:       drv[i] = ($urandom_range(0, 99) < 85);
        default: drv[i] = (i >= start);
      endcase
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!(req_ready && !rsp_valid && exp_q.size() == 0) && n < 300) begin
      @(posedge clk);
      #2;
      n++;
    end
    if (n >= 300) begin
      checks++;
      errors++;
      $display("FAIL idle_wait: block not idle after %0d cycles, %0d responses pending", n, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic issue(input logic [6:0] func);
    exp_q.push_back(model(func));
    @(posedge clk);
    #2;
    req_valid = 1'b1;
    req_func  = func;
    @(posedge clk);
    #2;
    req_valid = 1'b0;
  endtask

  // Responder: plays the script while strobe is high, random data otherwise.
  initial begin
    int idx = 0;
    forever begin
      @(posedge clk);
      #1;
      if (ebus_strobe && idx < TIMEOUT) begin
        ebus_driving = drv[idx];
        ebus_data    = dat[idx];
`ifdef EBUS_DIAG_PARITY_EN
        ebus_par     = par[idx];
`endif
        idx++;
      end else begin
        ebus_driving = 1'b0;
        ebus_data    = rand36();
        idx          = 0;
      end
    end
  end

  // Consumer: takes each response after ready_delay cycles.
  initial begin
    int wait_cnt = 0;
    forever begin
      @(posedge clk);
      #1;
      if (rsp_valid) begin
        if (wait_cnt >= ready_delay) begin
          rsp_ready = 1'b1;
        end else begin
          rsp_ready = 1'b0;
          wait_cnt++;
        end
      end else begin
        wait_cnt  = 0;
        rsp_ready = ready_noise ? 1'($urandom) : 1'b0;
      end
    end
  end

  // Monitor: pops the scoreboard on each new response and checks stability in HOLD.
  initial begin
    exp_t cur;
    bit   prev_valid = 1'b0;
    int   acc_cyc = 0;
    int   strobe_cnt = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_valid = 1'b0;
        strobe_cnt = 0;
        continue;
      end
      if (req_valid && req_ready) begin
        acc_cyc    = cyc + 1;
        strobe_cnt = 0;
      end
      if (ebus_strobe) begin
        strobe_cnt++;
        if (exp_q.size() > 0) check("strobe_diag", ebus_diag, exp_q[0].func);
      end
      if (rsp_valid && !prev_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rsp: data %0o with no request outstanding", rsp_data);
        end else begin
          cur = exp_q.pop_front();
          check("rsp_data", rsp_data, cur.data);
          check("rsp_timeout", rsp_timeout, cur.tmo);
          check("latency", cyc - acc_cyc, cur.lat);
          check("strobe_cycles", strobe_cnt, cur.nstrobe);
          check("hold_strobe", ebus_strobe, 0);
          check("hold_diag", ebus_diag, 0);
`ifdef EBUS_DIAG_PARITY_EN
          check("rsp_par_err", rsp_par_err, cur.par_err);
`endif
        end
      end else if (rsp_valid) begin
        check("hold_data_stable", rsp_data, cur.data);
        check("hold_tmo_stable", rsp_timeout, cur.tmo);
        check("hold_req_ready", req_ready, 0);
      end
      prev_valid = rsp_valid;
    end
  end

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #3;
    check("reset_req_ready", req_ready, 1);
    check("reset_rsp_valid", rsp_valid, 0);
    check("reset_rsp_data", rsp_data, 0);
    check("reset_rsp_timeout", rsp_timeout, 0);
    check("reset_diag", ebus_diag, 0);
    check("reset_strobe", ebus_strobe, 0);
    rst_n = 1'b1;

    // Immediate responder with a known word.
    wait_idle();
    fill(0);
    for (int i = 0; i < TIMEOUT; i++) dat[i] = 36'o123456701234;
    issue(7'o120);

    // Silent bus: full timeout.
    wait_idle();
    fill(1);
    issue(7'o121);

    // Glitching responder 1,0,1,1.
    wait_idle();
    fill(1);
    drv[0] = 1'b1; drv[2] = 1'b1; drv[3] = 1'b1;
    issue(7'o122);

    // Settle completes on the last allowed cycle: capture beats timeout.
    wait_idle();
    fill(1);
    drv[TIMEOUT-2] = 1'b1; drv[TIMEOUT-1] = 1'b1;
    issue(7'o123);

    // Driving only on the last cycle is too late.
    wait_idle();
    fill(1);
    drv[TIMEOUT-1] = 1'b1;
    issue(7'o124);

    // Slow consumer with a competing request during HOLD.
    wait_idle();
    ready_delay = 10;
    fill(0);
    issue(7'o125);
    n = 0;
    while (!rsp_valid && n < 200) begin
      @(posedge clk);
      #2;
      n++;
    end
    check("hold_reached", rsp_valid, 1);
    req_valid = 1'b1;
    req_func  = 7'o127;
    n = 0;
    while (!rsp_ready && n < 50) begin
      @(posedge clk);
      #2;
      n++;
    end
    req_valid   = 1'b0;
    ready_delay = 1;
    repeat (80) @(posedge clk);

    // Reset in the middle of STROBE.
    wait_idle();
    fill(1);
    issue(7'o126);
    n = 0;
    while (!ebus_strobe && n < 20) begin
      @(posedge clk);
      #2;
      n++;
    end
    check("strobe_reached", ebus_strobe, 1);
    repeat (5) @(posedge clk);
    #3;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("midop_req_ready", req_ready, 1);
    check("midop_rsp_valid", rsp_valid, 0);
    check("midop_rsp_data", rsp_data, 0);
    check("midop_rsp_timeout", rsp_timeout, 0);
    check("midop_diag", ebus_diag, 0);
    check("midop_strobe", ebus_strobe, 0);
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    wait_idle();
    fill(0);
    issue(7'o127);

`ifdef EBUS_DIAG_PARITY_EN
    wait_idle();
    fill(0);
    for (int i = 0; i < TIMEOUT; i++) begin dat[i] = '0; par[i] = 1'b0; end
    issue(7'o120);
    wait_idle();
    for (int i = 0; i < TIMEOUT; i++) par[i] = 1'b1;
    issue(7'o121);
`endif

    // Randomized traffic with a noisy, variably slow consumer.
    ready_noise = 1'b1;
    for (int t = 0; t < 40; t++) begin
      wait_idle();
      ready_delay = $urandom_range(0, 3);
      fill($urandom_range(0, 4));
      issue(7'o120 + 7'($urandom_range(0, 7)));
    end

    wait_idle();
    repeat (20) @(posedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
